// File: rtl/pyamnihc_count_uart_tx.sv
// 8N1 UART serializer for counter samples; valid/ready input, LSB-first frame on tx, wrapping frame counter.
// Accepts one sample per frame when idle and enabled; tx and busy are registered, in_ready is combinational.
module pyamnihc_count_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic [7:0]        frames_sent
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q;
  logic              busy_q;
  logic [7:0]        frames_q;

  logic take;
  logic bit_done;

  assign in_ready    = (state_q == IDLE) & ena & rst_n;
  assign take        = in_valid & in_ready;
  assign bit_done    = (cnt_q == CNT_MAX);
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (take) begin
            state_q <= START;
            cnt_q   <= '0;
            shift_q <= in_data;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              // next bit is driven straight from the pre-shift register
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            frames_q <= frames_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pyamnihc_count_uart_tx.md
Name: pyamnihc_count_uart_tx

Overview:
- Downstream stage of the dummy counter tile; consumes 8-bit count samples over a valid/ready handshake.
- Serializes each sample as an 8N1 UART frame on a single output pin, so the count can be read by an external host.
- Sits inside the tt_um wrapper between the counter core and uo_out[0].
- Also keeps a wrapping count of completed frames for debug on the spare outputs.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
DATA_W, 8, payload width; fixed at 8, present only for clarity.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; gates acceptance of new samples only
in_data  input  8  sample from counter stage
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample this cycle
tx  output  1  UART line; idles high
busy  output  1  high while a frame is in flight (any state except IDLE)
frames_sent  output  8  number of completed frames, wraps modulo 256

Behaviour:
- Reset: async assert of rst_n forces state=IDLE, tx=1, busy=0, frames_sent=0, bit and clock counters=0, shift register=0, immediately and regardless of clk. in_ready=0 while rst_n=0.
- in_ready is combinational: (state==IDLE) & ena & rst_n.
- Handshake:
  - Transfer occurs on a rising edge where in_valid & in_ready.
  - in_data is latched into the shift register at that edge; later in_data changes are ignored.
  - in_valid without in_ready has no effect; the upstream stage holds data.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1, busy=0; on transfer go to START, clear the clock counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA, bit index=0.
  - DATA: tx=shift[0], LSB first; every CLKS_PER_BIT cycles shift right and increment the bit index. After bit 7 has been held for CLKS_PER_BIT cycles, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE. frames_sent increments at the same edge.
- Timing: with the transfer at edge T, tx=0 during cycles T+1..T+C (C=CLKS_PER_BIT).
  - Data bit i is driven during T+1+C(1+i) .. T+C(2+i).
  - Stop bit is driven during T+1+9C .. T+10C.
  - IDLE (in_ready=1 if ena) from cycle T+10C+1.
  - Minimum spacing between accepted samples is 10C+1 cycles.
- tx and busy are registered outputs; they carry no combinational path from inputs.
- Clock counter width is ceil(log2(CLKS_PER_BIT)) bits and compares against CLKS_PER_BIT-1; no off-by-one drift across a frame.
- ena low mid-frame: the frame completes normally; only the next acceptance is blocked.
- ena low in IDLE: in_ready=0, tx stays 1.
- frames_sent wraps 255 -> 0 without a flag.
- Reset mid-frame: tx returns to 1 asynchronously, frame is abandoned, frames_sent=0. After release, block is in IDLE on the first clock edge.
- in_valid held high continuously: one sample is accepted per frame, on the first IDLE cycle.

Test Plan:
1. C=4, reset, ena=1, in_data=0xA5 with in_valid for 1 cycle.
   - Sampling tx every 4 cycles from T+1 gives 0,1,0,1,0,0,1,0,1,1.
   - busy high 40 cycles; frames_sent=1.
2. in_valid held high, data 0x00 then 0xFF.
   - Two frames; second start bit at T+42.
   - in_ready high exactly one cycle between frames; frames_sent=2.
3. ena=0 with in_valid=1 for 100 cycles.
   - in_ready=0, tx=1 throughout, frames_sent=0.
   - Raising ena starts a frame on the next edge.
4. Start frame 0x3C, assert rst_n=0 mid-bit 3 (between edges).
   - tx=1, busy=0 immediately; frames_sent=0.
   - After release, 0x81 is sent correctly.
5. Send 256 frames of an incrementing count.
   - frames_sent goes 255 -> 0.
   - A UART monitor decodes every byte equal to the stimulus.
6. C=2 (minimum): frame 0x5A.
   - Each bit held exactly 2 cycles; total 20 busy cycles.
